// File: rtl/reg_file.sv
// Integer register file: one write port from write-back, two combinational
// read ports to decode, write-through bypass and a load pending scoreboard.
module reg_file #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [4:0]        raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy1,
  input  logic              re2,
  input  logic [4:0]        raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy2,
  input  logic              mark,
  input  logic [4:0]        mark_addr,
  input  logic              flush
);

  logic [DATA_W-1:0]  r_regs [1:REG_NUM-1];
  logic [REG_NUM-1:1] r_pend;

  logic w_wr;
  logic w_set;

  assign w_wr  = rdy && we && (waddr != 5'd0);
  assign w_set = mark && (mark_addr != 5'd0) && !flush;

  // Architectural register array; x0 is never stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < REG_NUM; i++)
        r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Pending-load scoreboard: write-back clears, a newer mark wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_pend <= '0;
      end else begin
        if (w_wr)
          r_pend[waddr] <= 1'b0;
        if (w_set)
          r_pend[mark_addr] <= 1'b1;
      end
    end
  end

  // Read port 1 with write-through bypass.
  always_comb begin
    rdata1 = '0;
    busy1  = 1'b0;
    if (rst || !re1 || raddr1 == 5'd0) begin
      rdata1 = '0;
      busy1  = 1'b0;
    end else if (we && waddr == raddr1) begin
      rdata1 = wdata;
      busy1  = 1'b0;
    end else begin
      rdata1 = r_regs[raddr1];
      busy1  = r_pend[raddr1];
    end
  end

  // Read port 2 with write-through bypass.
  always_comb begin
    rdata2 = '0;
    busy2  = 1'b0;
    if (rst || !re2 || raddr2 == 5'd0) begin
      rdata2 = '0;
      busy2  = 1'b0;
    end else if (we && waddr == raddr2) begin
      rdata2 = wdata;
      busy2  = 1'b0;
    end else begin
      rdata2 = r_regs[raddr2];
      busy2  = r_pend[raddr2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: directed scenarios plus random traffic,
// compared against an array-based reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst, rdy, we, re1, re2, mark, flush;
  logic [4:0]  waddr, raddr1, raddr2, mark_addr;
  logic [31:0] wdata, rdata1, rdata2;
  logic        busy1, busy2;

  logic [31:0] m_regs [32];
  bit          m_pend [32];
  int          n_chk = 0;
  int          n_err = 0;

  reg_file #(.REG_NUM(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .busy1(busy1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .busy2(busy2),
    .mark(mark), .mark_addr(mark_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (rst || !re || a == 0) return 32'h0;
    if (we && waddr == a) return wdata;
    return m_regs[a];
  endfunction

  function automatic logic exp_bz(input logic re, input logic [4:0] a);
    if (rst || !re || a == 0) return 1'b0;
    if (we && waddr == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Drive inputs (called just after negedge), then check against the model.
  task automatic set(input logic r, input logic rd, input logic w,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic e1, input logic [4:0] a1,
                     input logic e2, input logic [4:0] a2,
                     input logic mk, input logic [4:0] ma, input logic fl);
    rst = r; rdy = rd; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    mark = mk; mark_addr = ma; flush = fl;
    #1;
    chk("rdata1", rdata1, exp_rd(re1, raddr1));
    chk("busy1", {31'h0, busy1}, {31'h0, exp_bz(re1, raddr1)});
    chk("rdata2", rdata2, exp_rd(re2, raddr2));
    chk("busy2", {31'h0, busy2}, {31'h0, exp_bz(re2, raddr2)});
  endtask

  // Advance one clock and apply the architectural update rules.
  task automatic adv();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (rdy) begin
      if (we && waddr != 0) begin
        m_regs[waddr] = wdata;
        m_pend[waddr] = 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else if (mark && mark_addr != 0) begin
        m_pend[mark_addr] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_rd(input logic [4:0] a1, input logic [4:0] a2);
    set(0, 1, 0, 0, 0, 1, a1, 1, a2, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    set(1, 1, 1, 5, 32'h1, 1, 5, 1, 5, 1, 5, 0);
    chk("rst_out", rdata1, 32'h0);
    adv();
    set(1, 1, 0, 0, 0, 1, 1, 1, 2, 0, 0, 0);
    adv();
    for (int i = 1; i < 32; i++) begin
      idle_rd(5'(i), 5'(32 - i));
      chk("rst_rd1", rdata1, 32'h0);
      chk("rst_bz2", {31'h0, busy2}, 32'h0);
      adv();
    end

    set(0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    adv();
    idle_rd(5, 0);
    chk("x5_rb", rdata1, 32'hDEADBEEF);
    adv();
    set(0, 1, 1, 0, 32'h12345678, 1, 0, 0, 0, 0, 0, 0);
    chk("x0_byp", rdata1, 32'h0);
    adv();
    idle_rd(0, 0);
    chk("x0_rd", rdata1, 32'h0);
    adv();

    set(0, 0, 1, 7, 32'hA5A5A5A5, 1, 7, 1, 7, 0, 0, 0);
    chk("byp1", rdata1, 32'hA5A5A5A5);
    chk("byp2", rdata2, 32'hA5A5A5A5);
    adv();
    idle_rd(7, 7);
    chk("rdy0_x7", rdata1, 32'h0);
    adv();

    set(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    chk("mark_lat", {31'h0, busy1}, 32'h0);
    adv();
    idle_rd(9, 9);
    chk("x9_busy", {31'h0, busy1}, 32'h1);
    adv();
    set(0, 1, 1, 9, 32'h55, 1, 9, 0, 0, 0, 0, 0);
    chk("x9_wb_bz", {31'h0, busy1}, 32'h0);
    chk("x9_wb_d", rdata1, 32'h55);
    adv();
    idle_rd(9, 9);
    chk("x9_nx_bz", {31'h0, busy1}, 32'h0);
    chk("x9_nx_d", rdata1, 32'h55);
    adv();

    set(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    adv();
    set(0, 1, 1, 3, 32'h33, 0, 0, 0, 0, 1, 3, 0);
    adv();
    idle_rd(3, 3);
    chk("x3_setwin", {31'h0, busy1}, 32'h1);
    chk("x3_data", rdata2, 32'h33);
    adv();
    set(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1);
    adv();
    idle_rd(4, 3);
    chk("x4_flush", {31'h0, busy1}, 32'h0);
    chk("x3_flushed", {31'h0, busy2}, 32'h0);
    adv();
    set(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
    adv();
    set(0, 1, 0, 0, 0, 1, 6, 0, 0, 0, 0, 1);
    chk("x6_pre", {31'h0, busy1}, 32'h1);
    adv();
    idle_rd(6, 6);
    chk("x6_post", {31'h0, busy1}, 32'h0);
    adv();

    set(0, 1, 1, 11, 32'h99, 0, 0, 0, 0, 1, 10, 0);
    adv();
    set(1, 1, 0, 0, 0, 1, 10, 1, 11, 0, 0, 0);
    adv();
    idle_rd(10, 11);
    chk("x10_rst", {31'h0, busy1}, 32'h0);
    chk("x11_rst", rdata2, 32'h0);
    adv();

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] wa, a1, a2, ma;
      logic [31:0] wd;
      wa = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a2 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ma = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wd = $urandom;
      set($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, wa, wd,
          $urandom_range(0, 7) != 0, a1, $urandom_range(0, 7) != 0, a2,
          $urandom_range(0, 2) == 0, ma, $urandom_range(0, 19) == 0);
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Integer register file at the far end of the write-back path: it accepts the single write port driven by the write-back stage and serves two combinational read ports to the decode stage. It holds 32 x 32-bit registers with x0 hard-wired to zero and provides write-through bypass for same-cycle write/read collisions. It also keeps a per-register pending-write scoreboard so that decode can detect a source whose producing load has not yet written back.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers; address width is 5.
- DATA_W, 32, register width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready; low freezes all state.
- we  in  1  write enable from write-back.
- waddr  in  5  write address.
- wdata  in  32  write data.
- re1  in  1  read port 1 enable.
- raddr1  in  5  read port 1 address.
- rdata1  out  32  read port 1 data (combinational).
- busy1  out  1  read port 1 source has a pending write.
- re2  in  1  read port 2 enable.
- raddr2  in  5  read port 2 address.
- rdata2  out  32  read port 2 data (combinational).
- busy2  out  1  read port 2 source has a pending write.
- mark  in  1  set pending bit for mark_addr (issuing load).
- mark_addr  in  5  destination of issuing load.
- flush  in  1  clear all pending bits.

## Operation
- Storage: regs[1..31], each DATA_W bits; regs[0] is not stored and always reads 0.
- Write: at posedge, if !rst && rdy && we && waddr!=0, regs[waddr] <= wdata. Writes to x0 are discarded.
- Scoreboard: pend[1..31]; pend[0] is constant 0.
  - Clear: a qualifying write (as above) clears pend[waddr].
  - Set: mark && mark_addr!=0 sets pend[mark_addr].
  - Same address set and clear in one cycle: set wins, so pend stays 1 because the newer load owns the register.
  - flush: clears every pend bit and overrides mark in the same cycle. A write in the same cycle still updates regs.
- Read port n (n=1,2), combinational, priority order:
  - rst high or re_n low: rdata_n=0, busy_n=0.
  - raddr_n==0: rdata_n=0, busy_n=0.
  - Bypass hit (we && waddr==raddr_n): rdata_n=wdata, busy_n=0. The bypass is independent of rdy.
  - Otherwise: rdata_n=regs[raddr_n], busy_n=pend[raddr_n].
- A mark in the current cycle does not affect busy_n until the next cycle.
- Both ports are fully independent and may read the same address.

## Timing
- Write latency: data is visible through the array one cycle after the write edge, and in the same cycle via bypass.
- Scoreboard latency: mark or flush takes effect on the next edge. A clear is visible the same cycle via bypass and in pend from the next edge.
- Reset: at a posedge with rst=1, all regs become 0 and all pend bits become 0. While rst=1, all outputs are 0.
- If reset is asserted mid-operation, in-flight marks are lost; rst wins over we, mark and flush.
- rdy=0: there are no regs or pend updates. Reads stay live and bypass remains active.
- No handshake: we, mark and flush are single-cycle pulses, each sampled once per qualifying edge.

## Test plan
- Reset then read: assert rst for 2 cycles, then read x1..x31 on both ports -> all rdata=0, busy=0.
- Write/readback plus x0: write x5=0xDEADBEEF, then the next cycle read raddr1=5 -> 0xDEADBEEF. Write x0=0x12345678, then read x0 -> 0.
- Bypass: in the same cycle drive we=1, waddr=7, wdata=0xA5A5A5A5 with raddr1=raddr2=7 -> both rdata=0xA5A5A5A5. With rdy=0 the bypass still shows it but regs[7] is unchanged on the next cycle.
- Scoreboard: mark x9, then the next cycle read x9 -> busy1=1. Write x9=0x55 -> same cycle busy1=0, rdata1=0x55. The next cycle shows busy1=0, rdata1=0x55.
- Collision and flush: with pend[3]=1, drive write x3 and mark x3 together -> pend[3] stays 1. mark x4 with flush together -> pend[4]=0. Next, mark x6 then flush -> busy on x6=0.
- Reset mid-operation: mark x10 and write x11=0x99, then assert rst one cycle -> x10 busy=0, x11 reads 0.
